// File: rtl/irq_pkg.sv
// Shared width helpers and vector-address arithmetic for the interrupt controller.
package irq_pkg;

  // Width of a channel index; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Width needed to count nesting levels 0..depth inclusive.
  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Vector address of a channel; callers truncate to their address width.
  function automatic logic [31:0] vec_addr(input logic [31:0] base, input int stride,
                                           input int id);
    return base + 32'(stride * id);
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: bit 0 has the highest priority.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int N = 8,
  localparam int IW = id_w(N)
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Nestable strict-priority interrupt controller with edge/level channels,
// a bounded in-service stack and sticky overflow/underflow flags.
module irq_controller
  import irq_pkg::*;
#(
  parameter int                N_IRQ      = 8,
  parameter int                ADDR_W     = 10,
  parameter int                DEPTH      = 4,
  parameter logic [ADDR_W-1:0] VEC_BASE   = 10'h3C0,
  parameter int                VEC_STRIDE = 4,
  localparam int               ID_W       = id_w(N_IRQ),
  localparam int               LVL_W      = lvl_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_IRQ-1:0]  irq,
  input  logic [N_IRQ-1:0]  enable,
  input  logic [N_IRQ-1:0]  edge_mode,
  input  logic              take,
  input  logic              reti,
  output logic              irq_req,
  output logic [ID_W-1:0]   irq_id,
  output logic [ADDR_W-1:0] irq_addr,
  output logic [N_IRQ-1:0]  pending,
  output logic [N_IRQ-1:0]  active,
  output logic              in_isr,
  output logic [LVL_W-1:0]  nest_level,
  output logic              nest_oflow,
  output logic              reti_uflow
);

  logic [N_IRQ-1:0] irq_q;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] active_q, active_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic             oflow_q, oflow_d;
  logic             uflow_q, uflow_d;
  logic [ID_W-1:0]  stack_q [DEPTH];

  logic [N_IRQ-1:0] cand;
  logic             win_valid;
  logic [ID_W-1:0]  win_idx;
  logic [ID_W-1:0]  top_id;
  logic             req_c;
  logic             do_push;
  logic             do_pop;

  assign cand = pending_q & enable & ~active_q;

  irq_prio_enc #(.N(N_IRQ)) u_enc (
    .req   (cand),
    .valid (win_valid),
    .idx   (win_idx)
  );

  // Request qualification, take/reti arbitration and next-state of all control state.
  always_comb begin
    top_id = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (lvl_q == LVL_W'(i + 1)) top_id = stack_q[i];
    end

    // A nested request must strictly outrank the channel currently in service.
    req_c = win_valid && ((lvl_q == '0) || (win_idx < top_id)) &&
            (lvl_q < LVL_W'(DEPTH));

    // reti wins over a simultaneous take.
    do_pop  = reti && (lvl_q != '0);
    do_push = take && !reti && req_c;

    oflow_d = oflow_q | (take && !reti && !req_c && (lvl_q == LVL_W'(DEPTH)));
    uflow_d = uflow_q | (reti && (lvl_q == '0));

    // A fresh edge outranks the clear from a take in the same cycle.
    pending_d = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (edge_mode[i]) begin
        pending_d[i] = (irq[i] & ~irq_q[i]) |
                       (pending_q[i] & ~(do_push && (win_idx == ID_W'(i))));
      end else begin
        pending_d[i] = irq[i];
      end
    end

    active_d = active_q;
    lvl_d    = lvl_q;
    if (do_push) begin
      active_d[win_idx] = 1'b1;
      lvl_d             = lvl_q + 1'b1;
    end else if (do_pop) begin
      active_d[top_id] = 1'b0;
      lvl_d            = lvl_q - 1'b1;
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_q     <= '0;
      pending_q <= '0;
      active_q  <= '0;
      lvl_q     <= '0;
      oflow_q   <= 1'b0;
      uflow_q   <= 1'b0;
    end else begin
      irq_q     <= irq;
      pending_q <= pending_d;
      active_q  <= active_d;
      lvl_q     <= lvl_d;
      oflow_q   <= oflow_d;
      uflow_q   <= uflow_d;
    end
  end

  // In-service stack: a push writes the slot addressed by the current level.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!reset) begin
        stack_q[i] <= '0;
      end else if (do_push && (lvl_q == LVL_W'(i))) begin
        stack_q[i] <= win_idx;
      end
    end
  end

  assign irq_req    = req_c;
  assign irq_id     = win_idx;
  assign irq_addr   = ADDR_W'(vec_addr(32'(VEC_BASE), VEC_STRIDE, int'(win_idx)));
  assign pending    = pending_q;
  assign active     = active_q;
  assign in_isr     = (lvl_q != '0);
  assign nest_level = lvl_q;
  assign nest_oflow = oflow_q;
  assign reti_uflow = uflow_q;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: two instances (DEPTH 4 and DEPTH 2) share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_irq_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq, enable, edge_mode;
  logic       take, reti;

  logic       req0, isr0, of0, uf0;
  logic [2:0] id0, lvl0;
  logic [9:0] addr0;
  logic [7:0] pend0, act0;

  logic       req1, isr1, of1, uf1;
  logic [2:0] id1;
  logic [1:0] lvl1;
  logic [9:0] addr1;
  logic [7:0] pend1, act1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  irq_controller #(.N_IRQ(8), .ADDR_W(10), .DEPTH(4), .VEC_BASE(10'h3C0), .VEC_STRIDE(4)) dut0 (
    .clk(clk), .reset(reset), .irq(irq), .enable(enable), .edge_mode(edge_mode),
    .take(take), .reti(reti), .irq_req(req0), .irq_id(id0), .irq_addr(addr0),
    .pending(pend0), .active(act0), .in_isr(isr0), .nest_level(lvl0),
    .nest_oflow(of0), .reti_uflow(uf0)
  );

  irq_controller #(.N_IRQ(8), .ADDR_W(10), .DEPTH(2), .VEC_BASE(10'h3C0), .VEC_STRIDE(4)) dut1 (
    .clk(clk), .reset(reset), .irq(irq), .enable(enable), .edge_mode(edge_mode),
    .take(take), .reti(reti), .irq_req(req1), .irq_id(id1), .irq_addr(addr1),
    .pending(pend1), .active(act1), .in_isr(isr1), .nest_level(lvl1),
    .nest_oflow(of1), .reti_uflow(uf1)
  );

  // ---------------- behavioural reference model ----------------
  int m_depth [2] = '{4, 2};
  bit m_pend  [2][8];
  bit m_act   [2][8];
  bit m_prev  [2][8];
  int m_stk   [2][8];
  int m_lvl   [2];
  bit m_of    [2];
  bit m_uf    [2];

  function automatic int m_winner(input int d);
    for (int i = 0; i < 8; i++)
      if (m_pend[d][i] && enable[i] && !m_act[d][i]) return i;
    return -1;
  endfunction

  function automatic bit m_req(input int d);
    int w;
    w = m_winner(d);
    if (w < 0) return 1'b0;
    if (m_lvl[d] >= m_depth[d]) return 1'b0;
    if (m_lvl[d] == 0) return 1'b1;
    return w < m_stk[d][m_lvl[d] - 1];
  endfunction

  task automatic m_step(input int d);
    int w;
    bit r;
    bit np [8];
    if (!reset) begin
      for (int i = 0; i < 8; i++) begin
        m_pend[d][i] = 0; m_act[d][i] = 0; m_prev[d][i] = 0;
      end
      m_lvl[d] = 0; m_of[d] = 0; m_uf[d] = 0;
    end else begin
      w = m_winner(d);
      r = m_req(d);
      for (int i = 0; i < 8; i++) begin
        if (edge_mode[i])
          np[i] = (irq[i] && !m_prev[d][i]) ||
                  (m_pend[d][i] && !(take && !reti && r && w == i));
        else
          np[i] = irq[i];
      end
      if (reti) begin
        if (m_lvl[d] > 0) begin
          m_lvl[d] = m_lvl[d] - 1;
          m_act[d][m_stk[d][m_lvl[d]]] = 0;
        end else begin
          m_uf[d] = 1;
        end
      end else if (take) begin
        if (r) begin
          m_stk[d][m_lvl[d]] = w;
          m_act[d][w] = 1;
          m_lvl[d] = m_lvl[d] + 1;
        end else if (m_lvl[d] == m_depth[d]) begin
          m_of[d] = 1;
        end
      end
      for (int i = 0; i < 8; i++) begin
        m_pend[d][i] = np[i];
        m_prev[d][i] = irq[i];
      end
    end
  endtask

  function automatic logic [7:0] m_bits(input int d, input bit act_not_pend);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = act_not_pend ? m_act[d][i] : m_pend[d][i];
    return v;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dut(input int d, input logic req, input logic [2:0] id,
                         input logic [9:0] addr, input logic [7:0] pend,
                         input logic [7:0] act, input logic isr, input logic [3:0] lvl,
                         input logic of, input logic uf);
    int w, eid;
    w   = m_winner(d);
    eid = (w < 0) ? 0 : w;
    chk($sformatf("d%0d.irq_req", d), 32'(req), 32'(m_req(d)));
    chk($sformatf("d%0d.irq_id", d), 32'(id), 32'(eid));
    chk($sformatf("d%0d.irq_addr", d), 32'(addr), (32'h3C0 + 32'(eid * 4)) & 32'h3FF);
    chk($sformatf("d%0d.pending", d), 32'(pend), 32'(m_bits(d, 1'b0)));
    chk($sformatf("d%0d.active", d), 32'(act), 32'(m_bits(d, 1'b1)));
    chk($sformatf("d%0d.in_isr", d), 32'(isr), 32'(m_lvl[d] != 0));
    chk($sformatf("d%0d.nest_level", d), 32'(lvl), 32'(m_lvl[d]));
    chk($sformatf("d%0d.nest_oflow", d), 32'(of), 32'(m_of[d]));
    chk($sformatf("d%0d.reti_uflow", d), 32'(uf), 32'(m_uf[d]));
  endtask

  // Advance one clock: model consumes the current inputs, DUT outputs are checked after the edge.
  task automatic cycle();
    m_step(0);
    m_step(1);
    @(posedge clk);
    #1;
    chk_dut(0, req0, id0, addr0, pend0, act0, isr0, {1'b0, lvl0}, of0, uf0);
    chk_dut(1, req1, id1, addr1, pend1, act1, isr1, {2'b00, lvl1}, of1, uf1);
  endtask

  task automatic pulse(input logic [7:0] v);
    irq = v;
    cycle();
    irq = 8'h00;
  endtask

  task automatic do_take();
    take = 1'b1;
    cycle();
    take = 1'b0;
  endtask

  task automatic do_reti();
    reti = 1'b1;
    cycle();
    reti = 1'b0;
  endtask

  initial begin
    reset = 1'b0; irq = 8'h00; enable = 8'hFF; edge_mode = 8'b1111_1011;
    take = 1'b0; reti = 1'b0;
    #1;
    cycle();
    cycle();
    chk("reset.irq_req", 32'(req0), 32'd0);
    chk("reset.irq_addr", 32'(addr0), 32'h3C0);
    reset = 1'b1;
    cycle();

    // Edge channel 3: one-cycle pulse, then take.
    pulse(8'h08);
    chk("e3.irq_req", 32'(req0), 32'd1);
    chk("e3.irq_id", 32'(id0), 32'd3);
    chk("e3.irq_addr", 32'(addr0), 32'h3CC);
    do_take();
    chk("e3.active", 32'(act0), 32'h08);
    chk("e3.pending", 32'(pend0), 32'h00);
    chk("e3.level", 32'(lvl0), 32'd1);

    // Preemption by channel 1, then channel 5 must wait for both retis.
    pulse(8'h02);
    chk("pre.irq_id", 32'(id0), 32'd1);
    do_take();
    chk("pre.level", 32'(lvl0), 32'd2);
    pulse(8'h20);
    chk("pre.blocked", 32'(req0), 32'd0);
    do_reti();
    chk("pre.still_blocked", 32'(req0), 32'd0);
    do_reti();
    chk("pre.ch5_req", 32'(req0), 32'd1);
    chk("pre.ch5_id", 32'(id0), 32'd5);
    do_take();
    do_reti();

    // Level channel 2 held high: masked while active, reasserts after reti.
    irq = 8'h04;
    cycle();
    chk("lvl.irq_id", 32'(id0), 32'd2);
    do_take();
    chk("lvl.masked", 32'(req0), 32'd0);
    chk("lvl.pending", 32'(pend0[2]), 32'd1);
    do_reti();
    chk("lvl.reassert", 32'(req0), 32'd1);
    irq = 8'h00;
    cycle();

    // Disabled channel latches pending but is not requested.
    enable = 8'hBF;
    pulse(8'h40);
    chk("dis.pending", 32'(pend0[6]), 32'd1);
    chk("dis.irq_req", 32'(req0), 32'd0);
    enable = 8'hFF;
    cycle();
    chk("dis.enabled", 32'(id0), 32'd6);
    do_take();
    do_reti();

    // Fill the DEPTH=2 instance, then a higher-priority edge overflows it.
    pulse(8'h10);
    do_take();
    pulse(8'h08);
    do_take();
    pulse(8'h01);
    chk("ovf.d1_req", 32'(req1), 32'd0);
    chk("ovf.d0_req", 32'(req0), 32'd1);
    do_take();
    chk("ovf.d1_oflow", 32'(of1), 32'd1);
    chk("ovf.d1_level", 32'(lvl1), 32'd2);
    chk("ovf.d0_level", 32'(lvl0), 32'd3);

    // Reset at level 3 with irq[0] held high across release.
    irq = 8'h01;
    reset = 1'b0;
    cycle();
    chk("rst.in_isr", 32'(isr0), 32'd0);
    chk("rst.level", 32'(lvl0), 32'd0);
    chk("rst.irq_addr", 32'(addr0), 32'h3C0);
    chk("rst.oflow", 32'(of1), 32'd0);
    cycle();
    reset = 1'b1;
    cycle();
    chk("rst.edge_after", 32'(pend0[0]), 32'd1);
    irq = 8'h00;
    do_take();

    // take+reti together at level 1: only the reti happens.
    pulse(8'h20);
    take = 1'b1; reti = 1'b1;
    cycle();
    take = 1'b0; reti = 1'b0;
    chk("tr.level", 32'(lvl0), 32'd0);
    chk("tr.active", 32'(act0), 32'h00);
    chk("tr.pend5", 32'(pend0[5]), 32'd1);

    // New edge on channel 3 in the same cycle it is taken keeps it pending.
    pulse(8'h08);
    cycle();
    irq = 8'h08;
    do_take();
    irq = 8'h00;
    chk("same.pend3", 32'(pend0[3]), 32'd1);
    chk("same.act3", 32'(act0[3]), 32'd1);
    do_reti();
    do_reti();
    chk("uflow.flag", 32'(uf0), 32'd1);

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(0, 63) != 0);
      irq       = 8'($urandom) & 8'($urandom);
      enable    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      if ($urandom_range(0, 31) == 0) edge_mode = 8'($urandom);
      take      = ($urandom_range(0, 2) == 0);
      reti      = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
